// File: rtl/cache_rsp_sched_if.sv
// ----------------------------------------------------------------------------
// cache_rsp_sched_if: bank-queue heads, pop strobes and registered grant bus
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface cache_rsp_sched_if #(
  parameter int NUM_BANKS   = 4,
  parameter int NUM_REQS    = 4,
  parameter int TAG_ID_BITS = 2,
  parameter int PERF_WIDTH  = 16
);
  localparam int TAG_W = (TAG_ID_BITS > 0) ? TAG_ID_BITS : 1;

  logic [NUM_BANKS-1:0]          per_bank_valid;
  logic [NUM_BANKS*TAG_W-1:0]    per_bank_tag_id;
  logic [NUM_BANKS*NUM_REQS-1:0] per_bank_lmask;
  logic [NUM_BANKS-1:0]          per_bank_ready;
  logic                          sel_valid;
  logic [NUM_BANKS-1:0]          sel_bank_mask;
  logic [NUM_REQS-1:0]           sel_lane_mask;
  logic [TAG_W-1:0]              sel_tag_id;
  logic                          sel_ready;
  logic [PERF_WIDTH-1:0]         perf_conflicts;

  // The bank queues and merge stage drive the master side; the scheduler is the slave.
  modport master (
    output per_bank_valid, per_bank_tag_id, per_bank_lmask, sel_ready,
    input  per_bank_ready, sel_valid, sel_bank_mask, sel_lane_mask, sel_tag_id, perf_conflicts
  );

  modport slave (
    input  per_bank_valid, per_bank_tag_id, per_bank_lmask, sel_ready,
    output per_bank_ready, sel_valid, sel_bank_mask, sel_lane_mask, sel_tag_id, perf_conflicts
  );
endinterface

`default_nettype wire

// File: rtl/cache_rsp_sched.sv
// ----------------------------------------------------------------------------
// cache_rsp_sched: round-robin tag-group grant ahead of the core-response merge
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cache_rsp_sched #(
  parameter int NUM_BANKS   = 4,
  parameter int NUM_REQS    = 4,
  parameter int TAG_ID_BITS = 2,
  parameter int PERF_WIDTH  = 16
) (
  input  wire logic        clk,
  input  wire logic        reset,
  cache_rsp_sched_if.slave bus
);
  localparam int TAG_W = (TAG_ID_BITS > 0) ? TAG_ID_BITS : 1;
  localparam int PTR_W = $clog2(NUM_BANKS);
  localparam int CNT_W = $clog2(NUM_BANKS + 1);
  localparam int SUM_W = ((PERF_WIDTH > CNT_W) ? PERF_WIDTH : CNT_W) + 1;

  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      leader;
  logic [PTR_W-1:0]      rr_next;
  logic [TAG_W-1:0]      leader_tag;
  logic [NUM_BANKS-1:0]  tag_eq;
  logic [NUM_BANKS-1:0]  included;
  logic [NUM_REQS-1:0]   acc;
  logic [CNT_W-1:0]      conflicts;
  logic [SUM_W-1:0]      perf_sum;
  logic [PERF_WIDTH-1:0] perf_next;
  logic                  any_valid;
  logic                  cap_en;

  assign any_valid = |bus.per_bank_valid;
  assign cap_en    = !bus.sel_valid || bus.sel_ready;

  // Scan backwards so the last hit is the first valid bank in cyclic order from rr_ptr.
  always_comb begin
    int               idx;
    logic [PTR_W-1:0] bi;
    idx    = 0;
    bi     = '0;
    leader = '0;
    for (int k = NUM_BANKS - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_BANKS) idx = idx - NUM_BANKS;
      bi = PTR_W'(idx);
      if (bus.per_bank_valid[bi]) leader = bi;
    end
  end

  assign leader_tag = (TAG_ID_BITS == 0) ? '0 : bus.per_bank_tag_id[int'(leader)*TAG_W +: TAG_W];

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_tag_eq
    if (TAG_ID_BITS == 0) begin : g_any
      assign tag_eq[i] = 1'b1;
    end else begin : g_cmp
      assign tag_eq[i] = (bus.per_bank_tag_id[i*TAG_W +: TAG_W] == leader_tag);
    end
  end

  // The leader is visited first with acc empty, so it always joins the group.
  always_comb begin
    int               idx;
    logic [PTR_W-1:0] bi;
    idx       = 0;
    bi        = '0;
    acc       = '0;
    included  = '0;
    conflicts = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      idx = int'(leader) + k;
      if (idx >= NUM_BANKS) idx = idx - NUM_BANKS;
      bi = PTR_W'(idx);
      if (bus.per_bank_valid[bi] && tag_eq[bi]) begin
        if ((bus.per_bank_lmask[idx*NUM_REQS +: NUM_REQS] & acc) == '0) begin
          included[bi] = 1'b1;
          acc          = acc | bus.per_bank_lmask[idx*NUM_REQS +: NUM_REQS];
        end else begin
          conflicts = conflicts + CNT_W'(1);
        end
      end
    end
  end

  assign bus.per_bank_ready = (reset && cap_en) ? included : '0;

  assign rr_next   = (leader == PTR_W'(NUM_BANKS - 1)) ? '0 : leader + PTR_W'(1);
  assign perf_sum  = SUM_W'(bus.perf_conflicts) + SUM_W'(conflicts);
  assign perf_next = (perf_sum > SUM_W'({PERF_WIDTH{1'b1}})) ? '1 : perf_sum[PERF_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.sel_valid      <= 1'b0;
      bus.sel_bank_mask  <= '0;
      bus.sel_lane_mask  <= '0;
      bus.sel_tag_id     <= '0;
      bus.perf_conflicts <= '0;
      rr_ptr             <= '0;
    end else if (cap_en) begin
      bus.sel_valid <= any_valid;
      if (any_valid) begin
        bus.sel_bank_mask  <= included;
        bus.sel_lane_mask  <= acc;
        bus.sel_tag_id     <= leader_tag;
        bus.perf_conflicts <= perf_next;
        rr_ptr             <= rr_next;
      end
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_cache_rsp_sched.sv
// ----------------------------------------------------------------------------
// tb_cache_rsp_sched: scoreboard bench for the round-robin response scheduler
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_cache_rsp_sched;
  localparam int NB = 4;
  localparam int NR = 4;
  localparam int TW = 2;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  logic done = 1'b0;

  always #5 clk = ~clk;

  cache_rsp_sched_if #(.NUM_BANKS(NB), .NUM_REQS(NR), .TAG_ID_BITS(TW), .PERF_WIDTH(16)) bus ();
  cache_rsp_sched_if #(.NUM_BANKS(NB), .NUM_REQS(NR), .TAG_ID_BITS(TW), .PERF_WIDTH(2))  bus2 ();

  cache_rsp_sched #(.NUM_BANKS(NB), .NUM_REQS(NR), .TAG_ID_BITS(TW), .PERF_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  cache_rsp_sched #(.NUM_BANKS(NB), .NUM_REQS(NR), .TAG_ID_BITS(TW), .PERF_WIDTH(2)) dut_sat (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  typedef struct {
    logic [NB-1:0] bank;
    logic [NR-1:0] lane;
    logic [TW-1:0] tag;
    int            conf;
    int            leader;
  } grant_t;

  grant_t q[$];
  logic   m_valid = 1'b0;
  int     m_rr    = 0;
  int     m_perf  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_bank(input int i, input logic v, input logic [TW-1:0] t, input logic [NR-1:0] m);
    bus.per_bank_valid[i]          = v;
    bus.per_bank_tag_id[i*TW +: TW] = t;
    bus.per_bank_lmask[i*NR +: NR]  = m;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference grant straight from the algorithm description, using the bench's own pointer.
  function automatic grant_t predict(input int rr);
    grant_t        g;
    logic [NR-1:0] a;
    int            j;
    g = '{bank: '0, lane: '0, tag: '0, conf: 0, leader: -1};
    a = '0;
    for (int k = 0; k < NB; k++) begin
      j = (rr + k) % NB;
      if (g.leader < 0 && bus.per_bank_valid[j]) g.leader = j;
    end
    if (g.leader >= 0) begin
      g.tag = bus.per_bank_tag_id[g.leader*TW +: TW];
      for (int k = 0; k < NB; k++) begin
        j = (g.leader + k) % NB;
        if (bus.per_bank_valid[j] && bus.per_bank_tag_id[j*TW +: TW] == g.tag) begin
          if ((bus.per_bank_lmask[j*NR +: NR] & a) == '0) begin
            g.bank[j] = 1'b1;
            a         = a | bus.per_bank_lmask[j*NR +: NR];
          end else begin
            g.conf++;
          end
        end
      end
      g.lane = a;
    end
    return g;
  endfunction

  // Scoreboard: the expected grant is pushed at the capture cycle and compared while it is held.
  always @(negedge clk) begin : mon
    grant_t g;
    check_eq("sel_valid", 32'(bus.sel_valid), 32'(m_valid));
    check_eq("perf", 32'(bus.perf_conflicts), 32'(m_perf));
    if (m_valid) begin
      check_eq("sb_depth", q.size(), 1);
      if (q.size() > 0) begin
        check_eq("sb_bank", 32'(bus.sel_bank_mask), 32'(q[0].bank));
        check_eq("sb_lane", 32'(bus.sel_lane_mask), 32'(q[0].lane));
        check_eq("sb_tag", 32'(bus.sel_tag_id), 32'(q[0].tag));
        if (bus.sel_ready && reset) void'(q.pop_front());
      end
    end
    if (!reset) begin
      check_eq("rst_ready", 32'(bus.per_bank_ready), 0);
      m_valid = 1'b0;
      m_rr    = 0;
      m_perf  = 0;
      q.delete();
    end else if ((!m_valid || bus.sel_ready) && (|bus.per_bank_valid)) begin
      g = predict(m_rr);
      check_eq("pop", 32'(bus.per_bank_ready), 32'(g.bank));
      q.push_back(g);
      m_valid = 1'b1;
      m_rr    = (g.leader + 1) % NB;
      m_perf  = (m_perf + g.conf > 65535) ? 65535 : m_perf + g.conf;
    end else begin
      check_eq("no_pop", 32'(bus.per_bank_ready), 0);
      if (!m_valid || bus.sel_ready) m_valid = 1'b0;
    end
  end

  initial begin
    #100000;
    check_eq("timeout", 32'(done), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    reset = 1'b0;
    bus.per_bank_valid = '0; bus.per_bank_tag_id = '0; bus.per_bank_lmask = '0; bus.sel_ready = 1'b1;
    bus2.per_bank_valid = '0; bus2.per_bank_tag_id = '0; bus2.per_bank_lmask = '0; bus2.sel_ready = 1'b1;
    tick(); tick();
    reset = 1'b1;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("idle_valid", 32'(bus.sel_valid), 0);
      check_eq("idle_ready", 32'(bus.per_bank_ready), 0);
    end
    check_eq("idle_perf", 32'(bus.perf_conflicts), 0);
    check_eq("idle_rr", 32'(dut.rr_ptr), 0);

    // Disjoint lanes, common tag: whole set in one grant
    tick();
    set_bank(0, 1, 2'd1, 4'b0001); set_bank(1, 1, 2'd1, 4'b0010);
    set_bank(2, 1, 2'd1, 4'b0100); set_bank(3, 1, 2'd1, 4'b1000);
    @(negedge clk);
    check_eq("all_pop", 32'(bus.per_bank_ready), 32'hf);
    tick();
    bus.per_bank_valid = '0;
    @(negedge clk);
    check_eq("all_bank", 32'(bus.sel_bank_mask), 32'hf);
    check_eq("all_lane", 32'(bus.sel_lane_mask), 32'hf);
    check_eq("all_tag", 32'(bus.sel_tag_id), 1);
    check_eq("all_rr", 32'(dut.rr_ptr), 1);

    // Fairness between banks 0 and 3 with different tags, starting from rr_ptr=1
    tick();
    set_bank(0, 1, 2'd0, 4'b0001); set_bank(3, 1, 2'd2, 4'b0001);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("fair_bank", 32'(bus.sel_bank_mask), (i % 2 == 0) ? 32'h8 : 32'h1);
    end

    // One more bank-3 grant at the next edge leaves rr_ptr=0 for the conflict case
    tick();
    bus.per_bank_valid = '0;
    set_bank(0, 1, 2'd3, 4'b0100); set_bank(1, 1, 2'd3, 4'b0100);
    @(negedge clk);
    check_eq("conf_rr", 32'(dut.rr_ptr), 0);
    @(posedge clk);
    @(negedge clk);
    check_eq("conf1_bank", 32'(bus.sel_bank_mask), 32'h1);
    check_eq("conf1_perf", 32'(bus.perf_conflicts), 1);
    @(posedge clk);
    @(negedge clk);
    check_eq("conf2_bank", 32'(bus.sel_bank_mask), 32'h2);
    check_eq("conf2_lane", 32'(bus.sel_lane_mask), 32'h4);
    check_eq("conf2_perf", 32'(bus.perf_conflicts), 2);

    // Backpressure: grant of bank 0 (tag 3) held while inputs churn
    tick();
    bus.sel_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.per_bank_valid  = NB'($urandom);
      bus.per_bank_tag_id = (NB*TW)'($urandom);
      bus.per_bank_lmask  = (NB*NR)'($urandom);
      @(negedge clk);
      check_eq("bp_bank", 32'(bus.sel_bank_mask), 32'h1);
      check_eq("bp_lane", 32'(bus.sel_lane_mask), 32'h4);
      check_eq("bp_tag", 32'(bus.sel_tag_id), 3);
      check_eq("bp_ready", 32'(bus.per_bank_ready), 0);
      tick();
    end
    bus.sel_ready = 1'b1;
    bus.per_bank_valid = '0;
    set_bank(2, 1, 2'd2, 4'b1000);
    @(negedge clk);
    check_eq("bp_release_pop", 32'(bus.per_bank_ready), 32'h4);
    tick();
    bus.per_bank_valid = '0;
    @(negedge clk);
    check_eq("bp_next_bank", 32'(bus.sel_bank_mask), 32'h4);
    check_eq("bp_next_lane", 32'(bus.sel_lane_mask), 32'h8);
    check_eq("bp_next_tag", 32'(bus.sel_tag_id), 2);

    // Random traffic, scoreboard only
    for (int i = 0; i < 80; i++) begin
      tick();
      bus.per_bank_valid  = NB'($urandom);
      bus.per_bank_tag_id = (NB*TW)'($urandom_range(0, 15));
      bus.per_bank_lmask  = (NB*NR)'($urandom);
      bus.sel_ready       = ($urandom_range(0, 3) != 0);
    end

    // Saturating counter on the narrow instance: one conflict per grant
    tick();
    bus2.per_bank_valid  = 4'b0011;
    bus2.per_bank_tag_id = '0;
    bus2.per_bank_lmask  = {4'b0000, 4'b0000, 4'b0001, 4'b0001};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("sat_perf", 32'(bus2.perf_conflicts), (i < 3) ? i + 1 : 3);
    end
    bus2.per_bank_valid = '0;

    // Reset while a grant is pending
    tick();
    bus.per_bank_valid = '0;
    set_bank(0, 1, 2'd1, 4'b0001);
    bus.sel_ready = 1'b1;
    tick();
    bus.sel_ready = 1'b0;
    @(negedge clk);
    check_eq("mid_pending", 32'(bus.sel_valid), 1);
    tick();
    reset = 1'b0;
    tick();
    check_eq("mid_valid", 32'(bus.sel_valid), 0);
    check_eq("mid_rr", 32'(dut.rr_ptr), 0);
    check_eq("mid_ready", 32'(bus.per_bank_ready), 0);
    reset = 1'b1;
    bus.sel_ready = 1'b1;
    tick();
    bus.per_bank_valid = '0;
    @(negedge clk);
    check_eq("mid_regrant", 32'(bus.sel_bank_mask), 32'h1);
    tick(); tick();
    check_eq("sb_drained", q.size(), 0);

    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/cache_rsp_sched.md
Name: cache_rsp_sched

Overview:
- Round-robin scheduler placed ahead of the cache core-response merge stage.
- Each cycle it picks one tag-id group from the per-bank response queues and grants every bank in that group whose destination lanes do not collide.
- It registers the grant for the merge datapath.
- It replaces fixed lowest-bank priority, preventing starvation of high-numbered banks and of lane-conflicting responses.

Parameters:
- NUM_BANKS, 4, number of cache banks (>=2).
- NUM_REQS, 4, number of core request lanes.
- TAG_ID_BITS, 2, width of the core tag id compared across banks; 0 means every valid bank matches.
- PERF_WIDTH, 16, width of the conflict counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- per_bank_valid  in  NUM_BANKS  bank has a response at head.
- per_bank_tag_id  in  NUM_BANKS*max(1,TAG_ID_BITS)  head tag id per bank.
- per_bank_lmask  in  NUM_BANKS*NUM_REQS  lanes written by each bank's head response.
- per_bank_ready  out  NUM_BANKS  pop strobe per bank.
- sel_valid  out  1  registered grant valid.
- sel_bank_mask  out  NUM_BANKS  banks included in the grant.
- sel_lane_mask  out  NUM_REQS  OR of the included banks' lmask.
- sel_tag_id  out  max(1,TAG_ID_BITS)  tag id of the group.
- sel_ready  in  1  downstream accepts the grant.
- perf_conflicts  out  PERF_WIDTH  saturating count of lane-conflict deferrals.

Behaviour:
Reset (reset==0 at a clk edge):
- sel_valid=0, sel_bank_mask=0, sel_lane_mask=0, sel_tag_id=0, rr_ptr=0, perf_conflicts=0.
- per_bank_ready=0 while reset is low.

Capture condition:
- cap_en = !sel_valid || sel_ready, i.e. a one-entry pipe register.
- A new grant is captured only when cap_en=1 and |per_bank_valid.

Leader:
- The leader is the first valid bank found scanning cyclically from rr_ptr (rr_ptr, rr_ptr+1, ... mod NUM_BANKS).

Group build, combinational, in the same cyclic order starting at the leader:
- acc = 0.
- Bank i is included if all of the following hold:
  - per_bank_valid[i]=1;
  - tag_id[i]==tag_id[leader] (always true when TAG_ID_BITS=0);
  - (lmask[i] & acc)==0.
- On inclusion, acc |= lmask[i].
- The leader is always included, even with an empty lmask.
- A bank that matches the tag but is excluded by lane overlap counts as one conflict.

Pop:
- per_bank_ready[i] = cap_en & included[i], asserted in the capture cycle only.
- per_bank_ready is combinational from inputs; the bank pops at that edge.
- Non-included banks hold their heads.

Register update on capture:
- sel_valid=1, sel_bank_mask=included, sel_lane_mask=acc, sel_tag_id=tag_id[leader].
- rr_ptr = (leader+1) mod NUM_BANKS.

Other cycles:
- sel_valid && !sel_ready: all sel_* outputs hold stable and per_bank_ready=0.
- cap_en=1 with no valid bank: sel_valid becomes 0 and rr_ptr is unchanged.

Throughput and latency:
- One grant per cycle with sel_ready held high.
- Latency is 1 cycle from bank valid to sel_valid.

perf_conflicts:
- On each capture, adds the number of conflicting banks in that cycle.
- Saturates at all-ones and never wraps.

Constraints:
- sel_tag_id is driven 0 when TAG_ID_BITS=0.
- Inputs of invalid banks are ignored and may be X; they must not propagate.

Reset mid-operation:
- A pending grant is dropped and sel_valid returns to 0 on the next edge.
- Banks keep their heads.

Test Plan:
1. Reset, then valid=4'b0000 -> sel_valid=0, per_bank_ready=0 for 10 cycles; perf_conflicts=0.
2. valid=4'b1111, all tag_id=1, lmask = 0001, 0010, 0100, 1000 for banks 0..3, sel_ready=1 -> per_bank_ready=1111 in a single cycle. Next cycle: sel_bank_mask=1111, sel_lane_mask=1111, sel_tag_id=1, rr_ptr=1.
3. Fairness: banks 0 and 3 always valid with different tags (0 and 2), lmask 0001 each, sel_ready=1. The granted bank must alternate 0,3,0,3 with rr_ptr advancing; neither bank may wait more than 2 grants.
4. Lane conflict: banks 0 and 1 valid, same tag 3, both lmask=0100, rr_ptr=0.
   - Grant 1: bank 0 alone, perf_conflicts=1.
   - Next grant: bank 1, sel_lane_mask=0100.
5. Backpressure: grant captured, then sel_ready=0 for 5 cycles while the bank inputs change. sel_* hold bit-identical and per_bank_ready=0. On the sel_ready=1 cycle the next grant is captured in that same cycle.
6. Saturation and mid-reset:
   - PERF_WIDTH=2 with a forced conflict on every grant: perf_conflicts goes 1,2,3,3.
   - reset=0 for one edge while sel_valid=1 -> sel_valid=0 and rr_ptr=0 after that edge.
